// File: rtl/clint_timer.sv
// Core-local interruptor: fractional RTC tick generator, 64-bit mtime,
// and per-hart mtimecmp/msip registers on a single-cycle memory bus.
`timescale 1ns/1ps
module clint_timer #(
  parameter int harts    = 1,
  parameter int clk_freq = 1000000000,
  parameter int rtc_freq = 100000000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             mem_valid,
  input  logic [31:0]      mem_addr,
  input  logic [31:0]      mem_wdata,
  input  logic [3:0]       mem_wstrb,
  output logic [31:0]      mem_rdata,
  output logic             mem_ready,
  output logic             rtc_tick,
  output logic [harts-1:0] mtip,
  output logic [harts-1:0] msip
);

  localparam logic [32:0] CLK_F        = 33'(clk_freq);
  localparam logic [32:0] RTC_F        = 33'(rtc_freq);
  localparam logic [13:0] WA_CMP_BASE  = 14'h1000;
  localparam logic [13:0] WA_MTIME_LO  = 14'h2FFE;
  localparam logic [13:0] WA_MTIME_HI  = 14'h2FFF;

  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_val,
    input logic [31:0] new_val,
    input logic [3:0]  strb
  );
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Word offset inside the 64 KiB window; the rest of the address is don't-care.
  logic [13:0] word_addr;
  logic        addr_unused;
  logic        is_write;
  logic        is_read;

  assign word_addr   = mem_addr[15:2];
  assign addr_unused = ^{mem_addr[31:16], mem_addr[1:0]};
  assign is_write    = mem_valid & (|mem_wstrb);
  assign is_read     = mem_valid & ~(|mem_wstrb);

  logic [31:0] acc_q, acc_d;
  logic        rtc_tick_q, rtc_tick_d;
  logic [32:0] acc_sum;
  logic [32:0] acc_wrap;

  always_comb begin
    acc_sum  = {1'b0, acc_q} + RTC_F;
    acc_wrap = acc_sum - CLK_F;
    if (acc_sum >= CLK_F) begin
      acc_d      = acc_wrap[31:0];
      rtc_tick_d = 1'b1;
    end else begin
      acc_d      = acc_sum[31:0];
      rtc_tick_d = 1'b0;
    end
  end

  logic [63:0] mtime_q, mtime_d;
  logic        mtime_lo_wr;
  logic        mtime_hi_wr;

  assign mtime_lo_wr = is_write && (word_addr == WA_MTIME_LO);
  assign mtime_hi_wr = is_write && (word_addr == WA_MTIME_HI);

  // A bus write to either half wins over the tick; that tick is lost.
  always_comb begin
    mtime_d = mtime_q;
    if (mtime_lo_wr) begin
      mtime_d[31:0] = merge_bytes(mtime_q[31:0], mem_wdata, mem_wstrb);
    end else if (mtime_hi_wr) begin
      mtime_d[63:32] = merge_bytes(mtime_q[63:32], mem_wdata, mem_wstrb);
    end else if (rtc_tick_q) begin
      mtime_d = mtime_q + 64'd1;
    end
  end

  logic [harts-1:0][63:0] cmp_all;
  logic [harts-1:0]       msip_all;
  logic [harts-1:0]       mtip_all;

  for (genvar gi = 0; gi < harts; gi++) begin : g_hart
    localparam logic [13:0] WA_MSIP   = 14'(gi);
    localparam logic [13:0] WA_CMP_LO = WA_CMP_BASE + 14'(2 * gi);
    localparam logic [13:0] WA_CMP_HI = WA_CMP_LO + 14'd1;

    logic [63:0] cmp_q, cmp_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;

    always_comb begin
      cmp_d  = cmp_q;
      msip_d = msip_q;
      mtip_d = (mtime_q >= cmp_q);
      if (is_write) begin
        if (word_addr == WA_CMP_LO) begin
          cmp_d[31:0] = merge_bytes(cmp_q[31:0], mem_wdata, mem_wstrb);
        end
        if (word_addr == WA_CMP_HI) begin
          cmp_d[63:32] = merge_bytes(cmp_q[63:32], mem_wdata, mem_wstrb);
        end
        if ((word_addr == WA_MSIP) && mem_wstrb[0]) begin
          msip_d = mem_wdata[0];
        end
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        cmp_q  <= '1;
        msip_q <= 1'b0;
        mtip_q <= 1'b0;
      end else begin
        cmp_q  <= cmp_d;
        msip_q <= msip_d;
        mtip_q <= mtip_d;
      end
    end

    assign cmp_all[gi]  = cmp_q;
    assign msip_all[gi] = msip_q;
    assign mtip_all[gi] = mtip_q;
  end

  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic        mem_ready_q, mem_ready_d;

  // Unmapped offsets and out-of-range harts fall through to zero.
  always_comb begin
    mem_ready_d = mem_valid;
    mem_rdata_d = '0;
    if (is_read) begin
      if (word_addr == WA_MTIME_LO) mem_rdata_d = mtime_q[31:0];
      if (word_addr == WA_MTIME_HI) mem_rdata_d = mtime_q[63:32];
      for (int h = 0; h < harts; h++) begin
        if (word_addr == 14'(h)) begin
          mem_rdata_d = {31'd0, msip_all[h]};
        end
        if (word_addr == WA_CMP_BASE + 14'(2 * h)) begin
          mem_rdata_d = cmp_all[h][31:0];
        end
        if (word_addr == WA_CMP_BASE + 14'(2 * h + 1)) begin
          mem_rdata_d = cmp_all[h][63:32];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q       <= '0;
      rtc_tick_q  <= 1'b0;
      mtime_q     <= '0;
      mem_ready_q <= 1'b0;
      mem_rdata_q <= '0;
    end else begin
      acc_q       <= acc_d;
      rtc_tick_q  <= rtc_tick_d;
      mtime_q     <= mtime_d;
      mem_ready_q <= mem_ready_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign mem_rdata = mem_rdata_q;
  assign mem_ready = mem_ready_q;
  assign rtc_tick  = rtc_tick_q;
  assign mtip      = mtip_all;
  assign msip      = msip_all;

endmodule

// File: tb/tb_clint_timer.sv
// Bench for clint_timer: a two-hart default-ratio instance checked every cycle
// against an arithmetic model, plus a 1000/300 fractional-ratio instance.
`timescale 1ns/1ps
module tb_clint_timer;

  localparam int      H   = 2;
  localparam longint  CF  = 1000000000;
  localparam longint  RF  = 100000000;
  localparam longint  FCF = 1000;
  localparam longint  FRF = 300;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          mem_valid = 1'b0;
  logic [31:0]   mem_addr = '0;
  logic [31:0]   mem_wdata = '0;
  logic [3:0]    mem_wstrb = '0;
  logic [31:0]   mem_rdata;
  logic          mem_ready;
  logic          rtc_tick;
  logic [H-1:0]  mtip;
  logic [H-1:0]  msip;

  logic          reset_f = 1'b1;
  logic          mem_valid_f = 1'b0;
  logic [31:0]   mem_addr_f = '0;
  logic [31:0]   mem_wdata_f = '0;
  logic [3:0]    mem_wstrb_f = '0;
  logic [31:0]   mem_rdata_f;
  logic          mem_ready_f;
  logic          rtc_tick_f;
  logic [0:0]    mtip_f;
  logic [0:0]    msip_f;

  clint_timer #(.harts(H), .clk_freq(int'(CF)), .rtc_freq(int'(RF))) dut (
    .clock(clk), .reset(reset), .mem_valid(mem_valid), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .rtc_tick(rtc_tick), .mtip(mtip), .msip(msip)
  );

  clint_timer #(.harts(1), .clk_freq(int'(FCF)), .rtc_freq(int'(FRF))) dut_frac (
    .clock(clk), .reset(reset_f), .mem_valid(mem_valid_f), .mem_addr(mem_addr_f),
    .mem_wdata(mem_wdata_f), .mem_wstrb(mem_wstrb_f), .mem_rdata(mem_rdata_f),
    .mem_ready(mem_ready_f), .rtc_tick(rtc_tick_f), .mtip(mtip_f), .msip(msip_f)
  );

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // Tick in cycle k after release iff floor(k*r/c) steps up at k.
  function automatic bit tick_of(input longint k, input longint r, input longint c);
    if (k <= 0) return 1'b0;
    return ((k * r) / c) != (((k - 1) * r) / c);
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] o, input logic [31:0] n,
                                             input logic [3:0] s);
    logic [31:0] r;
    r = o;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = n[8*b +: 8];
    return r;
  endfunction

  longint       j_m;
  logic [63:0]  mtime_m;
  logic [63:0]  cmp_m [H];
  logic [H-1:0] msip_m;
  logic [H-1:0] mtip_m;
  logic         ready_m;
  logic [31:0]  rdata_m;
  bit           mdl_valid = 1'b0;

  function automatic logic [31:0] mdl_read(input logic [31:0] a);
    int unsigned off;
    int unsigned h;
    off = {16'd0, a[15:2], 2'b00};
    if (off < 4 * H) return {31'd0, msip_m[off / 4]};
    if (off >= 'h4000 && off < 'h4000 + 8 * H) begin
      h = (off - 'h4000) / 8;
      return (off % 8 == 4) ? cmp_m[h][63:32] : cmp_m[h][31:0];
    end
    if (off == 'hBFF8) return mtime_m[31:0];
    if (off == 'hBFFC) return mtime_m[63:32];
    return 32'd0;
  endfunction

  always @(negedge clk) begin : cmp_proc
    bit          tk;
    bit          mtime_wr;
    int unsigned off;
    tk = tick_of(j_m, RF, CF);
    if (mdl_valid) begin
      check("rtc_tick", {63'd0, rtc_tick}, {63'd0, tk});
      check("mem_ready", {63'd0, mem_ready}, {63'd0, ready_m});
      check("mem_rdata", {32'd0, mem_rdata}, {32'd0, rdata_m});
      check("mtip", 64'(mtip), 64'(mtip_m));
      check("msip", 64'(msip), 64'(msip_m));
    end
    if (reset) begin
      j_m = 0; mtime_m = '0; msip_m = '0; mtip_m = '0; ready_m = 1'b0; rdata_m = '0;
      for (int h = 0; h < H; h++) cmp_m[h] = '1;
      mdl_valid = 1'b1;
    end else if (mdl_valid) begin
      for (int h = 0; h < H; h++) mtip_m[h] = (mtime_m >= cmp_m[h]);
      ready_m  = mem_valid;
      rdata_m  = (mem_valid && mem_wstrb == 4'd0) ? mdl_read(mem_addr) : 32'd0;
      mtime_wr = 1'b0;
      if (mem_valid && mem_wstrb != 4'd0) begin
        off = {16'd0, mem_addr[15:2], 2'b00};
        for (int h = 0; h < H; h++) begin
          if (off == 4 * h && mem_wstrb[0]) msip_m[h] = mem_wdata[0];
          if (off == 'h4000 + 8 * h) cmp_m[h][31:0]  = byte_merge(cmp_m[h][31:0], mem_wdata, mem_wstrb);
          if (off == 'h4004 + 8 * h) cmp_m[h][63:32] = byte_merge(cmp_m[h][63:32], mem_wdata, mem_wstrb);
        end
        if (off == 'hBFF8) begin mtime_m[31:0]  = byte_merge(mtime_m[31:0], mem_wdata, mem_wstrb);  mtime_wr = 1'b1; end
        if (off == 'hBFFC) begin mtime_m[63:32] = byte_merge(mtime_m[63:32], mem_wdata, mem_wstrb); mtime_wr = 1'b1; end
      end
      if (tk && !mtime_wr) mtime_m = mtime_m + 64'd1;
      j_m++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic bus(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] st,
                     output logic [31:0] rd, output logic rdy);
    mem_valid = 1'b1; mem_addr = a; mem_wdata = wd; mem_wstrb = st;
    step();
    mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
    rd  = mem_rdata;
    rdy = mem_ready;
    $display("[TB] cycle %0d %s addr=0x%04h wdata=0x%08h wstrb=%b -> ready=%0b rdata=0x%08h",
             cyc - 1, (st == 4'd0) ? "RD" : "WR", a[15:0], wd, st, rdy, rd);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      begin : main_seq
        logic [31:0] rd, rd_lo, rd_hi;
        logic        rdy, rdy_lo, rdy_hi;
        repeat (3) step();
        check("reset mem_ready", {63'd0, mem_ready}, 64'd0);
        check("reset mem_rdata", {32'd0, mem_rdata}, 64'd0);
        check("reset rtc_tick", {63'd0, rtc_tick}, 64'd0);
        check("reset mtip", 64'(mtip), 64'd0);
        check("reset msip", 64'(msip), 64'd0);
        reset = 1'b0;
        cyc = 0;
        for (int c = 1; c <= 100; c++) begin
          step();
          check("tick every 10", {63'd0, rtc_tick}, (c % 10 == 0) ? 64'd1 : 64'd0);
        end
        step();
        check("idle mtip", 64'(mtip), 64'd0);
        check("idle msip", 64'(msip), 64'd0);
        bus(32'h0000_BFF8, 32'd0, 4'h0, rd, rdy);
        check("mtime after 100 cycles", {32'd0, rd}, 64'd10);
        check("read ready", {63'd0, rdy}, 64'd1);

        bus(32'h0000_0004, 32'd1, 4'hF, rd, rdy);
        step();
        check("msip hart1 set", 64'(msip), 64'h2);
        bus(32'h0000_0004, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        bus(32'h0000_0004, 32'd0, 4'h0, rd, rdy);
        check("msip readback", {32'd0, rd}, 64'h1);
        bus(32'h0000_0008, 32'd0, 4'h0, rd, rdy);
        check("msip out of range", {32'd0, rd}, 64'h0);
        check("unmapped ready", {63'd0, rdy}, 64'd1);

        bus(32'h0000_4004, 32'd0, 4'hF, rd, rdy);
        bus(32'h0000_4000, 32'h20, 4'hF, rd, rdy);
        while (mtip[0] !== 1'b1 && cyc < 400) step();
        check("mtip0 rise cycle", 64'(cyc), 64'd322);
        check("mtip1 stays low", {63'd0, mtip[1]}, 64'd0);

        while (cyc < 330) step();
        check("tick cycle 330", {63'd0, rtc_tick}, 64'd1);
        bus(32'h0000_BFF8, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        bus(32'h0000_BFF8, 32'd0, 4'h0, rd, rdy);
        check("mtime lo after tick-cycle write", {32'd0, rd}, 64'hFFFF_FFFF);
        bus(32'h0000_BFFC, 32'd0, 4'h0, rd, rdy);
        check("mtime hi after tick-cycle write", {32'd0, rd}, 64'h0);

        while (cyc < 341) step();
        bus(32'h0000_BFF8, 32'd0, 4'h0, rd_lo, rdy_lo);
        bus(32'h0000_BFFC, 32'd0, 4'h0, rd_hi, rdy_hi);
        check("b2b ready lo", {63'd0, rdy_lo}, 64'd1);
        check("b2b ready hi", {63'd0, rdy_hi}, 64'd1);
        check("wrapped mtime lo", {32'd0, rd_lo}, 64'h0);
        check("carried mtime hi", {32'd0, rd_hi}, 64'h1);

        mem_valid = 1'b1; mem_addr = 32'h0000_BFF8; mem_wstrb = 4'h0;
        step();
        check("first of pair ready", {63'd0, mem_ready}, 64'd1);
        mem_addr = 32'h0000_BFFC; reset = 1'b1;
        step();
        mem_valid = 1'b0; mem_addr = '0;
        check("ready suppressed by reset", {63'd0, mem_ready}, 64'd0);
        repeat (2) step();
        reset = 1'b0;
        repeat (5) step();
      end
      begin : frac_seq
        int  cnt;
        int  last;
        bit  tk;
        cnt = 0; last = 0;
        repeat (3) @(posedge clk);
        #1;
        reset_f = 1'b0;
        for (int c = 1; c <= 1000; c++) begin
          @(posedge clk);
          #1;
          tk = tick_of(longint'(c), FRF, FCF);
          check("frac tick", {63'd0, rtc_tick_f}, {63'd0, tk});
          if (rtc_tick_f) begin
            if (last != 0) check("frac spacing 3 or 4", ((c - last == 3) || (c - last == 4)) ? 64'd1 : 64'd0, 64'd1);
            last = c;
            cnt++;
          end
        end
        check("frac tick count", 64'(cnt), 64'd300);
        @(posedge clk);
        #1;
        mem_valid_f = 1'b1; mem_addr_f = 32'h0000_BFF8;
        @(posedge clk);
        #1;
        mem_valid_f = 1'b0; mem_addr_f = '0;
        $display("[TB] frac RD addr=0xbff8 -> ready=%0b rdata=0x%08h", mem_ready_f, mem_rdata_f);
        check("frac ready", {63'd0, mem_ready_f}, 64'd1);
        check("frac mtime", {32'd0, mem_rdata_f}, 64'd300);
      end
    join
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/clint_timer.md
# clint_timer

Parametrised multi-hart core-local interruptor. Derives an exact-average RTC tick from the core clock with a phase accumulator, maintains the 64-bit `mtime` counter, and holds per-hart `mtimecmp` and `msip` registers. It sits on the data memory bus behind the CLINT window decoder and drives `mtip` and `msip` into each hart's interrupt logic. It generalises the fixed integer `clk_divider_rtc` scheme to arbitrary clock/RTC ratios and N harts.

## Interface
- `harts`, 1: number of harts served (1..8).
- `clk_freq`, 1000000000: core clock frequency in Hz (< 2^31).
- `rtc_freq`, 100000000: RTC tick frequency in Hz (1 ≤ `rtc_freq` ≤ `clk_freq`).
- `clock`  in  1: core clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `mem_valid`  in  1: request strobe, one cycle per request.
- `mem_addr`  in  32: byte address; only bits [15:0] are decoded as an offset into the CLINT window; bits [1:0] are ignored.
- `mem_wdata`  in  32: write data.
- `mem_wstrb`  in  4: byte enables; all zero means read.
- `mem_rdata`  out  32: read data, valid while `mem_ready`=1.
- `mem_ready`  out  1: response strobe.
- `rtc_tick`  out  1: one-cycle pulse when `mtime` advances.
- `mtip`  out  `harts`: machine timer interrupt pending, one bit per hart.
- `msip`  out  `harts`: machine software interrupt pending, one bit per hart.

## Operation
- Register map (offsets):
  - `msip[h]` at 0x0000+4h; only bit 0 is writable, other bits read 0.
  - `mtimecmp[h]` lo/hi at 0x4000+8h and 0x4004+8h.
  - `mtime` lo/hi at 0xBFF8 and 0xBFFC.
  - All other offsets, including hart indices ≥ `harts`: reads return 0 and writes are ignored. These accesses are still acknowledged.
- Writes honour `mem_wstrb` per byte.
- Tick generator: 32-bit accumulator `acc`.
  - Each cycle compute `sum` = `acc` + `rtc_freq`.
  - If `sum` ≥ `clk_freq`: `rtc_tick`=1 next cycle and `acc` ← `sum` − `clk_freq`.
  - Otherwise `acc` ← `sum`.
  - The long-run tick rate is exactly `rtc_freq`; there is no cumulative drift.
- `mtime` increments by 1 (64-bit wrap 0xFFFF_FFFF_FFFF_FFFF→0) in the same cycle `rtc_tick` is asserted.
- Bus write to `mtime` lo or hi in the same cycle as an increment: the written bytes take the write data. Unwritten bytes keep their old value, and the increment for that cycle is dropped; the other 32-bit half is not incremented.
- `mtip[h]` is registered: `mtip[h]` ← (`mtime` ≥ `mtimecmp[h]`), 64-bit unsigned, evaluated on the current register values.
- `msip[h]` output equals bit 0 of the `msip[h]` register.

## Timing
- Reset values:
  - `mem_ready`=0, `mem_rdata`=0, `rtc_tick`=0, `mtip`=0, `msip`=0.
  - `acc`=0, `mtime`=0, `mtimecmp[*]`=all ones.
- Bus latency:
  - `mem_valid` in cycle n gives `mem_ready`=1 in n+1 only. No wait states.
  - Requests may arrive every cycle and each is answered in order.
  - Without a request, `mem_ready`=0 and `mem_rdata`=0.
- Read data is sampled in cycle n: it reflects register state before any update at the end of n.
- Write visibility:
  - A write in cycle n is visible to a read issued in n+1.
  - `mtip` reflects a new `mtimecmp` or `mtime` in n+2.
- Tick timing with defaults (ratio 10): first `rtc_tick` occurs in the 10th cycle after `reset` deasserts, then every 10 cycles.
- Reset asserted mid-transaction: a `mem_ready` due in the next cycle is suppressed and the write is discarded if sampled with `reset`=1.
- `mtip` follows `mtimecmp` writes combinationally in one register stage. Writing `mtimecmp` hi then lo may glitch `mtip` for one cycle; software is responsible for ordering.

## Test plan
- Reset release, defaults, 100 cycles idle:
  - `rtc_tick` pulses at cycles 10, 20, …, 100.
  - `mtime` reads 10.
  - `mtip`=0 and `msip`=0.
- Fractional ratio, `clk_freq`=1000, `rtc_freq`=300, 1000 cycles:
  - Exactly 300 ticks.
  - Tick spacing only 3 or 4 cycles.
- `harts`=2:
  - Write 1 to offset 0x0004 → `msip`=2'b10 two cycles later.
  - Write 0xFFFFFFFF to offset 0x0004 → readback 0x1.
  - Read offset 0x0008 → 0.
- Write `mtimecmp[0]` = 0x0000_0000_0000_0020, hart 0, defaults:
  - `mtip[0]` rises two cycles after `mtime` reaches 0x20.
  - `mtip[1]` stays 0.
- Write `mtime` lo = 0xFFFF_FFFF with `wstrb`=4'hF in a tick cycle:
  - The tick is dropped and readback is 0xFFFF_FFFF.
  - The next tick wraps lo to 0 and increments hi.
- Back-to-back reads of 0xBFF8 and 0xBFFC in consecutive cycles:
  - `mem_ready` is high two consecutive cycles with the correct halves.
  - Asserting `reset` during the second request suppresses its `mem_ready`.
